// File: rtl/div_sched.sv
// ============================================================================
// div_sched : round-robin scheduler sharing one restoring array divider
//             among four requesters, with a fixed multicycle settling window.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module div #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH-1:0] quot_o,
   output logic             dbz_o
);

   logic [WIDTH:0] rem;
   logic [WIDTH:0] diff;

   // One restoring row per quotient bit, MSB first; a clear borrow keeps the difference.
   always_comb begin
      rem    = '0;
      diff   = '0;
      quot_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         rem  = {rem[WIDTH-1:0], dividend_i[i]};
         diff = rem - {1'b0, divisor_i};
         if (!diff[WIDTH]) begin
            rem       = diff;
            quot_o[i] = 1'b1;
         end
      end
   end

   assign dbz_o = (divisor_i == '0);

endmodule

module div_sched #(
   parameter int WIDTH = 8,
   parameter int LAT   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [3:0]         req_valid,
   output logic [3:0]         req_ready,
   input  logic [4*WIDTH-1:0] req_dividend,
   input  logic [4*WIDTH-1:0] req_divisor,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [1:0]         rsp_id,
   output logic [WIDTH-1:0]   rsp_quot,
   output logic               rsp_dbz,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         ptr_q, ptr_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [1:0]         id_q, id_d;
   logic [1:0]         rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]   rsp_quot_q, rsp_quot_d;
   logic               rsp_dbz_q, rsp_dbz_d;

   logic               win_found;
   logic [1:0]         win_idx;
   logic [1:0]         cand;
   logic [3:0]         grant;
   logic [WIDTH-1:0]   div_quot;
   logic               div_dbz;

   // Operands are held in registers so the divider path can settle over LAT cycles.
   div #(.WIDTH(WIDTH)) u_div (
      .dividend_i (op_a_q),
      .divisor_i  (op_b_q),
      .quot_o     (div_quot),
      .dbz_o      (div_dbz)
   );

   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      cand      = ptr_q;
      for (int k = 0; k < 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      id_d       = id_q;
      rsp_id_d   = rsp_id_q;
      rsp_quot_d = rsp_quot_q;
      rsp_dbz_d  = rsp_dbz_q;
      grant      = '0;
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant[win_idx] = 1'b1;
               op_a_d  = req_dividend[int'(win_idx)*WIDTH +: WIDTH];
               op_b_d  = req_divisor[int'(win_idx)*WIDTH +: WIDTH];
               id_d    = win_idx;
               ptr_d   = win_idx + 2'd1;
               cnt_d   = 4'(LAT);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd1) begin
               rsp_quot_d = div_dbz ? '1 : div_quot;
               rsp_dbz_d  = div_dbz;
               rsp_id_d   = id_q;
               state_d    = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         op_a_q     <= '0;
         op_b_q     <= '0;
         id_q       <= '0;
         rsp_id_q   <= '0;
         rsp_quot_q <= '0;
         rsp_dbz_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         op_a_q     <= op_a_d;
         op_b_q     <= op_b_d;
         id_q       <= id_d;
         rsp_id_q   <= rsp_id_d;
         rsp_quot_q <= rsp_quot_d;
         rsp_dbz_q  <= rsp_dbz_d;
      end
   end

   // Grants are gated by reset directly so nothing is offered while rst_n is low.
   assign req_ready = rst_n ? grant : 4'b0000;
   assign rsp_valid = (state_q == S_RESP);
   assign busy      = (state_q != S_IDLE);
   assign rsp_id    = rsp_id_q;
   assign rsp_quot  = rsp_quot_q;
   assign rsp_dbz   = rsp_dbz_q;

endmodule

`default_nettype wire

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one combinational `div` instance (restoring array divider, WIDTH-bit) between four requesters. It grants one requester at a time and registers that requester's operands onto the divider inputs. It holds them stable for a fixed multicycle settling window, then captures quotient and divide-by-zero into a response register with a valid/ready handshake. It sits between the four client blocks and the single shared divider, so the long combinational divide path is treated as a multicycle path.

## Interface
Parameters:
- WIDTH, 8, operand/quotient width; passed to the internal `div` instance.
- LAT, 2, settling cycles allowed for the divider; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; one clock, asynchronous assert, active-low.
- req_valid  input  4  per-requester request; bit i belongs to requester i.
- req_ready  output  4  one-hot grant/accept; zero when idle-less or in reset.
- req_dividend  input  4*WIDTH  requester i dividend at bits [i*WIDTH +: WIDTH].
- req_divisor  input  4*WIDTH  requester i divisor, same packing.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  2  index of requester that owns the response.
- rsp_quot  output  WIDTH  quotient.
- rsp_dbz  output  1  divisor was zero.
- busy  output  1  high whenever state != IDLE.

## Operation
- States: IDLE, WAIT, RESP. Reset state IDLE.
- IDLE: winner = first i with req_valid[i]=1, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). req_ready = one-hot(winner) combinationally; all zero if no valid. Accept = req_valid[i] & req_ready[i] at an edge.
- On accept: op_a <= dividend[winner], op_b <= divisor[winner], id <= winner, ptr <= winner+1 mod 4, cnt <= LAT, state -> WAIT.
- op_a/op_b drive the `div` instance directly. They change only on accept.
- WAIT: each edge, if cnt==1, capture: rsp_quot <= div out, rsp_dbz <= div dbz, rsp_id <= id, state -> RESP. Otherwise cnt <= cnt-1.
- Divide by zero: rsp_dbz=1 and rsp_quot forced to all ones (8'hFF at WIDTH=8), independent of divider output.
- RESP: rsp_valid=1. Outputs hold until rsp_valid & rsp_ready at an edge, then state -> IDLE. No new grant occurs in the RESP cycle.
- req_ready is zero in WAIT and RESP.
- Requesters must hold valid and operands until accepted. A deasserted valid before accept simply drops out of arbitration.

## Timing
- Reset (async, rst_n low): state=IDLE, ptr=0, cnt=0, op_a=op_b=0, rsp_valid=0, rsp_id=0, rsp_quot=0, rsp_dbz=0, busy=0. req_ready is forced 0 while rst_n is low.
- Reset mid-operation: in-flight op is discarded with no response. The requester re-arbitrates after reset release, with ptr=0.
- Latency: accept at edge k means rsp_valid is high after edge k+LAT.
- Minimum spacing between accepts is LAT+2 cycles: LAT in WAIT, at least one in RESP, one in IDLE.
- Back-pressure: RESP can last indefinitely. rsp_* must be stable while rsp_valid=1 and rsp_ready=0.
- Fairness: a requester with valid held continuously waits at most 3 other grants.
- Quotient is the unsigned floor(dividend/divisor) for nonzero divisor.

## Test plan
- Single request, LAT=2: requester 2 with 200/7, accepted at edge k → rsp_valid after edge k+2, rsp_id=2, rsp_quot=28, rsp_dbz=0, busy high for 3 cycles with rsp_ready=1.
- All four valid continuously from reset: operands i*50+10 / i+1 → grants in order 0,1,2,3,0. Quotients 10,30,36,40. req_ready is never more than one-hot.
- Divide by zero: 55/0 on requester 1 → rsp_dbz=1, rsp_quot=8'hFF. Next request 255/255 → quot 1, dbz 0.
- Back-pressure: rsp_ready held low 5 cycles → rsp_valid and rsp_id/quot/dbz stable. req_ready stays 0 and no new accept occurs until one cycle after the rsp handshake.
- Reset mid-WAIT: drop rst_n during WAIT → all outputs zero immediately. After release, the request is still valid and is re-granted with a correct result, and exactly one response is produced.
- Exhaustive-ish at LAT=1: random 8-bit operands on random requesters, 1000 ops → every response matches floor division, and rsp_id matches the accepted requester.
